// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS/DLX IF stage: PC register, IF/ID pipeline register, stall and redirect handling
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instruc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  // The read address comes straight from the PC register, never from stall/redirect.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      if_id_instruc <= NOP_WORD;
      if_id_pc4     <= 32'd0;
      if_id_valid   <= 1'b0;
      fetch_count   <= 32'd0;
    end else if (redirect) begin
      // Redirect wins over stall; the wrong-path word is dropped as a bubble.
      pc            <= {redirect_pc[31:2], 2'b00};
      if_id_instruc <= NOP_WORD;
      if_id_pc4     <= 32'd0;
      if_id_valid   <= 1'b0;
    end else if (!stall) begin
      pc            <= pc_plus4;
      if_id_instruc <= imem_data;
      if_id_pc4     <= pc_plus4;
      if_id_valid   <= 1'b1;
      fetch_count   <= fetch_count + 32'd1;
    end
  end

endmodule
